// File: rtl/dcache_param_if.sv
// Datapath, memory-side and coherence signals between the CPU side and the data cache.
interface dcache_param_if;
    logic        halt;
    logic        dmemREN;
    logic        dmemWEN;
    logic        datomic;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        dhit;
    logic [31:0] dmemload;
    logic        flushed;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ccwait;
    logic        ccinv;
    logic [31:0] ccsnoopaddr;
    logic        ccwrite;
    logic        cctrans;
    logic [31:0] hit_count;

    // Datapath / memory / coherence side
    modport master (
        output halt, dmemREN, dmemWEN, datomic, dmemaddr, dmemstore,
        output dwait, dload, ccwait, ccinv, ccsnoopaddr,
        input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore,
        input  ccwrite, cctrans, hit_count
    );

    // Cache side
    modport slave (
        input  halt, dmemREN, dmemWEN, datomic, dmemaddr, dmemstore,
        input  dwait, dload, ccwait, ccinv, ccsnoopaddr,
        output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore,
        output ccwrite, cctrans, hit_count
    );
endinterface

// File: rtl/dcache_param.sv
// Parameterised set-associative write-back data cache with LRU replacement,
// flush-on-halt, snoop responses and LL/SC link register.
module dcache_param #(
    parameter int unsigned WAYS  = 2,
    parameter int unsigned SETS  = 8,
    parameter int unsigned WORDS = 2
) (
    input  logic          CLK,
    input  logic          nRST,
    dcache_param_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned OFF_W = $clog2(WORDS);
    localparam int unsigned TAG_W = 32 - IDX_W - OFF_W - 2;
    localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned AGE_W = WAY_W;
    localparam int unsigned FRM_W = $clog2(SETS * WAYS);
    localparam int unsigned CNT_W = OFF_W;

    typedef enum logic [2:0] {IDLE, WB, FETCH, FLSCAN, FLWB, DONE} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [FRM_W-1:0]   fp_q;
    logic [WAY_W-1:0]   miss_way_q;
    logic               replay_q;
    logic [31:0]        lr_addr_q;
    logic               lr_valid_q;
    logic [31:0]        hit_count_q;

    logic [TAG_W-1:0]   tag_q   [WAYS][SETS];
    logic               valid_q [WAYS][SETS];
    logic               dirty_q [WAYS][SETS];
    logic [31:0]        data_q  [WAYS][SETS][WORDS];
    logic [AGE_W-1:0]   age_q   [WAYS][SETS];

    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   idx;
    logic [OFF_W-1:0]   off;
    logic [TAG_W-1:0]   s_tag;
    logic [IDX_W-1:0]   s_idx;
    logic [OFF_W-1:0]   s_off;
    logic [IDX_W-1:0]   f_set;
    logic [WAY_W-1:0]   f_way;

    logic               hit;
    logic [WAY_W-1:0]   hit_way;
    logic               s_hit;
    logic [WAY_W-1:0]   s_way;
    logic               victim_found;
    logic [WAY_W-1:0]   victim;
    logic [AGE_W-1:0]   oldest;

    logic               req;
    logic               is_sc;
    logic               sc_ok;
    logic               cnt_last;
    logic               lru_en;
    logic [WAY_W-1:0]   lru_way;

    assign req_tag  = bus.dmemaddr[31 -: TAG_W];
    assign idx      = bus.dmemaddr[2 + OFF_W +: IDX_W];
    assign off      = bus.dmemaddr[2 +: OFF_W];
    assign s_tag    = bus.ccsnoopaddr[31 -: TAG_W];
    assign s_idx    = bus.ccsnoopaddr[2 + OFF_W +: IDX_W];
    assign s_off    = bus.ccsnoopaddr[2 +: OFF_W];
    assign f_set    = fp_q[IDX_W-1:0];
    assign f_way    = WAY_W'(fp_q >> IDX_W);
    assign req      = bus.dmemREN | bus.dmemWEN;
    assign is_sc    = bus.dmemWEN & bus.datomic;
    assign sc_ok    = lr_valid_q && (lr_addr_q == bus.dmemaddr);
    assign cnt_last = (cnt_q == CNT_W'(WORDS - 1));
    assign bus.hit_count = hit_count_q;

    // Tag lookup for the datapath address, snoop address and victim choice
    always_comb begin
        hit          = 1'b0;
        hit_way      = '0;
        s_hit        = 1'b0;
        s_way        = '0;
        victim_found = 1'b0;
        victim       = '0;
        oldest       = age_q[0][idx];
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[w][idx] && (tag_q[w][idx] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!s_hit && valid_q[w][s_idx] && (tag_q[w][s_idx] == s_tag)) begin
                s_hit = 1'b1;
                s_way = WAY_W'(w);
            end
            if (!victim_found && !valid_q[w][idx]) begin
                victim_found = 1'b1;
                victim       = WAY_W'(w);
            end
        end
        if (!victim_found) begin
            for (int w = 1; w < WAYS; w++) begin
                if (age_q[w][idx] > oldest) begin
                    oldest = age_q[w][idx];
                    victim = WAY_W'(w);
                end
            end
        end
    end

    // Datapath, memory and coherence responses; a snoop cycle suppresses everything else
    always_comb begin
        bus.dhit     = 1'b0;
        bus.dmemload = '0;
        bus.flushed  = (state_q == DONE);
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ccwrite  = 1'b0;
        bus.cctrans  = 1'b0;
        if (bus.ccwait) begin
            if (s_hit) begin
                bus.ccwrite = 1'b1;
                bus.dstore  = data_q[s_way][s_idx][s_off];
                bus.daddr   = bus.ccsnoopaddr;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (!bus.halt && req && hit) begin
                        bus.dhit = 1'b1;
                        if (bus.dmemWEN) begin
                            if (is_sc) bus.dmemload = {31'd0, sc_ok};
                            if (!is_sc || sc_ok) begin
                                bus.cctrans = 1'b1;
                                bus.daddr   = bus.dmemaddr;
                            end
                        end else begin
                            bus.dmemload = data_q[hit_way][idx][off];
                        end
                    end
                end
                WB: begin
                    bus.dWEN   = 1'b1;
                    bus.daddr  = {tag_q[miss_way_q][idx], idx, cnt_q, 2'b00};
                    bus.dstore = data_q[miss_way_q][idx][cnt_q];
                end
                FETCH: begin
                    bus.dREN  = 1'b1;
                    bus.daddr = {req_tag, idx, cnt_q, 2'b00};
                end
                FLWB: begin
                    bus.dWEN   = 1'b1;
                    bus.daddr  = {tag_q[f_way][f_set], f_set, cnt_q, 2'b00};
                    bus.dstore = data_q[f_way][f_set][cnt_q];
                end
                default: ;
            endcase
        end
    end

    // LRU touch: a hit (except a failed SC) or the completion of a fill
    always_comb begin
        lru_en  = 1'b0;
        lru_way = hit_way;
        if (!bus.ccwait) begin
            if (state_q == IDLE && !bus.halt && req && hit && !(is_sc && !sc_ok)) begin
                lru_en = 1'b1;
            end else if (state_q == FETCH && !bus.dwait && cnt_last) begin
                lru_en  = 1'b1;
                lru_way = miss_way_q;
            end
        end
    end

    // Per-set age counters: touched way to 0, others age with saturation
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int w = 0; w < WAYS; w++)
                for (int s = 0; s < SETS; s++)
                    age_q[w][s] <= '0;
        end else if (lru_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == lru_way)
                    age_q[w][idx] <= '0;
                else if (age_q[w][idx] != '1)
                    age_q[w][idx] <= age_q[w][idx] + AGE_W'(1);
            end
        end
    end

    // Controller state, frame arrays, link register and hit counter
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            fp_q        <= '0;
            miss_way_q  <= '0;
            replay_q    <= 1'b0;
            lr_addr_q   <= '0;
            lr_valid_q  <= 1'b0;
            hit_count_q <= '0;
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    tag_q[w][s]   <= '0;
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                    for (int k = 0; k < WORDS; k++)
                        data_q[w][s][k] <= '0;
                end
            end
        end else if (bus.ccwait) begin
            if (s_hit) begin
                dirty_q[s_way][s_idx] <= 1'b0;
                if (bus.ccinv) valid_q[s_way][s_idx] <= 1'b0;
            end
            if (bus.ccsnoopaddr == lr_addr_q) lr_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    replay_q <= 1'b0;
                    if (bus.halt) begin
                        state_q <= FLSCAN;
                        fp_q    <= '0;
                        cnt_q   <= '0;
                    end else if (req) begin
                        if (hit) begin
                            if (!replay_q) hit_count_q <= hit_count_q + 32'd1;
                            if (bus.dmemWEN) begin
                                if (!is_sc || sc_ok) begin
                                    data_q[hit_way][idx][off] <= bus.dmemstore;
                                    dirty_q[hit_way][idx]     <= 1'b1;
                                end
                                if (is_sc || (bus.dmemaddr == lr_addr_q)) lr_valid_q <= 1'b0;
                            end else if (bus.datomic) begin
                                lr_addr_q  <= bus.dmemaddr;
                                lr_valid_q <= 1'b1;
                            end
                        end else begin
                            miss_way_q <= victim;
                            cnt_q      <= '0;
                            if (valid_q[victim][idx] && dirty_q[victim][idx]) begin
                                state_q <= WB;
                            end else begin
                                state_q               <= FETCH;
                                valid_q[victim][idx]  <= 1'b0;
                            end
                        end
                    end
                end
                WB: begin
                    if (!bus.dwait) begin
                        if (cnt_last) begin
                            cnt_q                     <= '0;
                            state_q                   <= FETCH;
                            valid_q[miss_way_q][idx]  <= 1'b0;
                            dirty_q[miss_way_q][idx]  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                FETCH: begin
                    if (!bus.dwait) begin
                        data_q[miss_way_q][idx][cnt_q] <= bus.dload;
                        if (cnt_last) begin
                            cnt_q                     <= '0;
                            tag_q[miss_way_q][idx]    <= req_tag;
                            valid_q[miss_way_q][idx]  <= 1'b1;
                            dirty_q[miss_way_q][idx]  <= 1'b0;
                            replay_q                  <= 1'b1;
                            state_q                   <= IDLE;
                            if (bus.dmemREN && !bus.dmemWEN && bus.datomic) begin
                                lr_addr_q  <= bus.dmemaddr;
                                lr_valid_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                FLSCAN: begin
                    if (valid_q[f_way][f_set] && dirty_q[f_way][f_set]) begin
                        state_q <= FLWB;
                        cnt_q   <= '0;
                    end else if (fp_q == FRM_W'(SETS * WAYS - 1)) begin
                        state_q <= DONE;
                    end else begin
                        fp_q <= fp_q + FRM_W'(1);
                    end
                end
                FLWB: begin
                    if (!bus.dwait) begin
                        if (cnt_last) begin
                            cnt_q                 <= '0;
                            dirty_q[f_way][f_set] <= 1'b0;
                            state_q               <= FLSCAN;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_q <= DONE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_param.sv
// Directed bench for dcache_param (WAYS=2, SETS=8, WORDS=2): fills, write-back,
// flush, snoop, LL/SC and reset mid-fetch. Memory returns 0xD0000000 | address.
module tb_dcache_param;
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    logic wait_mode = 1'b0;
    logic dwait_t = 1'b0;
    int   checks = 0;
    int   passed = 0;

    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    logic [31:0] rd_addr_q [$];

    dcache_param_if bus ();

    dcache_param #(.WAYS(2), .SETS(8), .WORDS(2)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    assign bus.dwait = dwait_t;
    assign bus.dload = 32'hD000_0000 | bus.daddr;

    always @(posedge CLK) dwait_t <= wait_mode ? ~dwait_t : 1'b0;

    // Memory-side log of accepted transfers, sampled mid low phase
    always @(negedge CLK) begin
        #2;
        if (nRST && bus.dWEN && !bus.dwait) begin
            wr_addr_q.push_back(bus.daddr);
            wr_data_q.push_back(bus.dstore);
        end
        if (nRST && bus.dREN && !bus.dwait) rd_addr_q.push_back(bus.daddr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit wr_has(input int from, input logic [31:0] a, input logic [31:0] d);
        for (int i = from; i < wr_addr_q.size(); i++)
            if (wr_addr_q[i] == a && wr_data_q[i] == d) return 1'b1;
        return 1'b0;
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0;
        bus.halt = 1'b0; bus.dmemREN = 1'b0; bus.dmemWEN = 1'b0; bus.datomic = 1'b0;
        bus.ccwait = 1'b0; bus.ccinv = 1'b0;
        wait_mode = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    // Issue one request at a negedge and hold it until dhit (bounded)
    task automatic access(input logic wen, input logic atom, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] load,
                          output logic trans, output int cyc);
        bus.dmemREN   = ~wen;
        bus.dmemWEN   = wen;
        bus.datomic   = atom;
        bus.dmemaddr  = addr;
        bus.dmemstore = wdata;
        cyc = 0;
        #1;
        while (!bus.dhit && cyc < 60) begin
            @(negedge CLK);
            #1;
            cyc++;
        end
        chk("access_dhit", 32'(bus.dhit), 32'd1);
        load  = bus.dmemload;
        trans = bus.cctrans;
        @(negedge CLK);
        bus.dmemREN = 1'b0;
        bus.dmemWEN = 1'b0;
        bus.datomic = 1'b0;
    endtask

    initial begin
        logic [31:0] ld;
        logic        tr;
        int          cyc;
        int          base;
        int          rbase;

        bus.halt = 1'b0; bus.dmemREN = 1'b0; bus.dmemWEN = 1'b0; bus.datomic = 1'b0;
        bus.dmemaddr = '0; bus.dmemstore = '0;
        bus.ccwait = 1'b0; bus.ccinv = 1'b0; bus.ccsnoopaddr = '0;
        do_reset();
        #1;
        chk("rst_dhit", 32'(bus.dhit), 32'd0);
        chk("rst_hit_count", bus.hit_count, 32'd0);
        chk("rst_dREN", 32'(bus.dREN), 32'd0);
        chk("rst_dWEN", 32'(bus.dWEN), 32'd0);
        chk("rst_flushed", 32'(bus.flushed), 32'd0);

        // Cold read: two-word fetch then replay hit not counted
        @(negedge CLK);
        rbase = rd_addr_q.size();
        access(1'b0, 1'b0, 32'h100, 32'h0, ld, tr, cyc);
        chk("cold_load", ld, 32'hD000_0100);
        chk("cold_cycles", 32'(cyc), 32'd3);
        chk("cold_rd_count", 32'(rd_addr_q.size() - rbase), 32'd2);
        chk("cold_rd0", rd_addr_q[rbase], 32'h100);
        chk("cold_rd1", rd_addr_q[rbase + 1], 32'h104);
        chk("cold_hit_count", bus.hit_count, 32'd0);
        access(1'b0, 1'b0, 32'h104, 32'h0, ld, tr, cyc);
        chk("reread_load", ld, 32'hD000_0104);
        chk("reread_cycles", 32'(cyc), 32'd0);
        chk("reread_hit_count", bus.hit_count, 32'd1);

        // Write hit then read back
        access(1'b1, 1'b0, 32'h100, 32'h1111_1111, ld, tr, cyc);
        chk("whit_cycles", 32'(cyc), 32'd0);
        chk("whit_cctrans", 32'(tr), 32'd1);
        access(1'b0, 1'b0, 32'h100, 32'h0, ld, tr, cyc);
        chk("whit_readback", ld, 32'h1111_1111);
        chk("whit_hit_count", bus.hit_count, 32'd3);

        // Set 0: fill free way, then third tag evicts LRU dirty 0x100 line
        base = wr_addr_q.size();
        access(1'b1, 1'b0, 32'h400, 32'h2222_2222, ld, tr, cyc);
        chk("fill2_cycles", 32'(cyc), 32'd3);
        chk("fill2_no_wb", 32'(wr_addr_q.size() - base), 32'd0);
        access(1'b1, 1'b0, 32'h800, 32'h3333_3333, ld, tr, cyc);
        chk("evict_cycles", 32'(cyc), 32'd5);
        chk("evict_wb_count", 32'(wr_addr_q.size() - base), 32'd2);
        chk("evict_wb0_addr", wr_addr_q[base], 32'h100);
        chk("evict_wb0_data", wr_data_q[base], 32'h1111_1111);
        chk("evict_wb1_addr", wr_addr_q[base + 1], 32'h104);
        chk("evict_wb1_data", wr_data_q[base + 1], 32'hD000_0104);
        access(1'b1, 1'b0, 32'h108, 32'h4444_4444, ld, tr, cyc);
        chk("replay_hit_count", bus.hit_count, 32'd3);

        // Flush three dirty frames with a stalling memory
        base = wr_addr_q.size();
        wait_mode = 1'b1;
        bus.halt  = 1'b1;
        cyc = 0;
        #1;
        while (!bus.flushed && cyc < 300) begin
            @(negedge CLK);
            #1;
            cyc++;
        end
        chk("flush_done", 32'(bus.flushed), 32'd1);
        chk("flush_wr_count", 32'(wr_addr_q.size() - base), 32'd6);
        chk("flush_0x800", 32'(wr_has(base, 32'h800, 32'h3333_3333)), 32'd1);
        chk("flush_0x804", 32'(wr_has(base, 32'h804, 32'hD000_0804)), 32'd1);
        chk("flush_0x108", 32'(wr_has(base, 32'h108, 32'h4444_4444)), 32'd1);
        chk("flush_0x400", 32'(wr_has(base, 32'h400, 32'h2222_2222)), 32'd1);
        repeat (6) @(negedge CLK);
        #1;
        chk("flush_hold", 32'(bus.flushed), 32'd1);
        chk("flush_idle_dWEN", 32'(bus.dWEN), 32'd0);
        chk("flush_no_extra", 32'(wr_addr_q.size() - base), 32'd6);

        // LL then SC to the same address succeeds and leaves the line dirty
        do_reset();
        access(1'b0, 1'b1, 32'h200, 32'h0, ld, tr, cyc);
        chk("ll_load", ld, 32'hD000_0200);
        access(1'b1, 1'b1, 32'h200, 32'h5555_5555, ld, tr, cyc);
        chk("sc_ok_load", ld, 32'd1);
        chk("sc_ok_cctrans", 32'(tr), 32'd1);
        access(1'b0, 1'b0, 32'h200, 32'h0, ld, tr, cyc);
        chk("sc_ok_stored", ld, 32'h5555_5555);
        chk("sc_hit_count", bus.hit_count, 32'd2);
        base = wr_addr_q.size();
        access(1'b0, 1'b0, 32'h400, 32'h0, ld, tr, cyc);
        access(1'b0, 1'b0, 32'h800, 32'h0, ld, tr, cyc);
        chk("sc_dirty_wb_count", 32'(wr_addr_q.size() - base), 32'd2);
        chk("sc_dirty_wb", 32'(wr_has(base, 32'h200, 32'h5555_5555)), 32'd1);

        // LL, invalidating snoop, then SC fails without touching memory
        do_reset();
        access(1'b0, 1'b1, 32'h200, 32'h0, ld, tr, cyc);
        base = wr_addr_q.size();
        bus.dmemREN     = 1'b1;
        bus.dmemaddr    = 32'h200;
        bus.ccwait      = 1'b1;
        bus.ccinv       = 1'b1;
        bus.ccsnoopaddr = 32'h200;
        #1;
        chk("snoop_dhit_blocked", 32'(bus.dhit), 32'd0);
        chk("snoop_ccwrite", 32'(bus.ccwrite), 32'd1);
        chk("snoop_dstore", bus.dstore, 32'hD000_0200);
        chk("snoop_daddr", bus.daddr, 32'h200);
        @(negedge CLK);
        bus.ccinv = 1'b0;
        #1;
        chk("snoop_miss_ccwrite", 32'(bus.ccwrite), 32'd0);
        @(negedge CLK);
        bus.ccwait  = 1'b0;
        bus.dmemREN = 1'b0;
        access(1'b1, 1'b1, 32'h200, 32'h6666_6666, ld, tr, cyc);
        chk("sc_fail_miss_cycles", 32'(cyc), 32'd3);
        chk("sc_fail_load", ld, 32'd0);
        chk("sc_fail_cctrans", 32'(tr), 32'd0);
        chk("sc_fail_no_write", 32'(wr_addr_q.size() - base), 32'd0);
        access(1'b0, 1'b0, 32'h200, 32'h0, ld, tr, cyc);
        chk("sc_fail_unchanged", ld, 32'hD000_0200);
        chk("sc_fail_hit_count", bus.hit_count, 32'd1);

        // Reset during FETCH word 1 abandons the fill
        do_reset();
        bus.dmemREN  = 1'b1;
        bus.dmemaddr = 32'h300;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        chk("midfetch_dREN", 32'(bus.dREN), 32'd1);
        chk("midfetch_word1", bus.daddr, 32'h304);
        nRST = 1'b0;
        #1;
        chk("midfetch_rst_dREN", 32'(bus.dREN), 32'd0);
        bus.dmemREN = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        access(1'b0, 1'b0, 32'h300, 32'h0, ld, tr, cyc);
        chk("midfetch_remiss", 32'(cyc), 32'd3);
        chk("midfetch_load", ld, 32'hD000_0300);
        chk("midfetch_hit_count", bus.hit_count, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
